spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 208 ++++++++++++++++++++
 tb/tb_spi_slave_if.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI responder, oversampled in clk_i, with valid/ready TX and RX streams
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO instead of the single RX register.
module spi_slave_if #(
   parameter int DATA_W = 8,
   parameter bit CPOL   = 1'b0,
   parameter bit CPHA   = 1'b0
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              spi_ssel_i,
   input  logic              spi_sck_i,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              rx_overrun_o,
   output logic              tx_underrun_o,
   input  logic              status_clr_i,
   output logic              busy_o
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic              ssel_s1, ssel_s2, sck_s1, sck_s2, sck_s3, mosi_s1, mosi_s2;
   logic              armed;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_shift, tx_shift, hold_data, word_src;
   logic              hold_full, out_bit, ur_pending, word_done;
   logic              sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, drive_edge;
   logic              word_end, slot_start, slot_next, underrun_set, overrun_set;

   // SSEL syncs reset to "selected" so a frame already running at reset release is ignored
   // until SSEL has been seen high (armed).
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ssel_s1 <= 1'b0;
         ssel_s2 <= 1'b0;
         sck_s1  <= CPOL;
         sck_s2  <= CPOL;
         sck_s3  <= CPOL;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         ssel_s1 <= spi_ssel_i;
         ssel_s2 <= ssel_s1;
         sck_s1  <= spi_sck_i;
         sck_s2  <= sck_s1;
         sck_s3  <= sck_s2;
         mosi_s1 <= spi_mosi_i;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sck_rise    = sck_s2 & ~sck_s3;
   assign sck_fall    = ~sck_s2 & sck_s3;
   assign lead_edge   = CPOL ? sck_fall : sck_rise;
   assign trail_edge  = CPOL ? sck_rise : sck_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign drive_edge  = CPHA ? lead_edge : trail_edge;

   assign word_end   = sample_edge && (bit_cnt == LAST_BIT);
   assign slot_start = (state == IDLE) && armed && !ssel_s2;
   assign slot_next  = (state == SHIFT) && !ssel_s2 && word_end;
   assign word_src   = hold_full ? hold_data : '0;
   assign tx_ready_o = !hold_full;

   // A continuation slot with no data is only reported once the master actually clocks
   // the next word, so the end of a frame never flags an underrun.
   assign underrun_set = (slot_start && !hold_full) ||
                         ((state == SHIFT) && !ssel_s2 && lead_edge && ur_pending);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         busy_o     <= 1'b0;
         armed      <= 1'b0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         hold_data  <= '0;
         hold_full  <= 1'b0;
         out_bit    <= 1'b0;
         ur_pending <= 1'b0;
         word_done  <= 1'b0;
         spi_miso_o <= 1'b0;
      end else begin
         word_done  <= 1'b0;
         spi_miso_o <= (state == SHIFT) && out_bit;
         if (ssel_s2) armed <= 1'b1;
         if (tx_valid_i && !hold_full) begin
            hold_data <= tx_data_i;
            hold_full <= 1'b1;
         end
         case (state)
            IDLE: begin
               bit_cnt    <= '0;
               ur_pending <= 1'b0;
               if (slot_start) begin
                  state  <= SHIFT;
                  busy_o <= 1'b1;
               end
            end
            SHIFT: begin
               if (ssel_s2) begin
                  state      <= IDLE;
                  busy_o     <= 1'b0;
                  bit_cnt    <= '0;
                  ur_pending <= 1'b0;
               end else begin
                  if (lead_edge) ur_pending <= 1'b0;
                  if (sample_edge) begin
                     rx_shift <= {rx_shift[DATA_W-2:0], mosi_s2};
                     if (word_end) begin
                        bit_cnt    <= '0;
                        word_done  <= 1'b1;
                        ur_pending <= !hold_full;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  // With CPHA=0 the trailing edge after the last bit must not shift:
                  // the next word's MSB is already on the line from the slot start.
                  if (drive_edge && (CPHA || (bit_cnt != '0))) begin
                     out_bit  <= tx_shift[DATA_W-1];
                     tx_shift <= tx_shift << 1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
         if (slot_start || slot_next) begin
            if (hold_full) hold_full <= 1'b0;
            if (CPHA) begin
               tx_shift <= word_src;
            end else begin
               out_bit  <= word_src[DATA_W-1];
               tx_shift <= word_src << 1;
            end
         end
      end
   end

`ifdef SPI_SLAVE_RX_FIFO_EN
   logic [DATA_W-1:0] fifo_mem [4];
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        fill;
   logic              push, pop;

   assign pop         = rx_ready_i && (fill != 3'd0);
   assign push        = word_done && ((fill != 3'd4) || pop);
   assign overrun_set = word_done && (fill == 3'd4) && !pop;
   assign rx_valid_o  = (fill != 3'd0);
   assign rx_data_o   = fifo_mem[rd_ptr];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= rx_shift;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) fill <= fill + 1'b1;
         else if (pop && !push) fill <= fill - 1'b1;
      end
   end
`else
   assign overrun_set = word_done && rx_valid_o && !rx_ready_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
      end else if (word_done && (!rx_valid_o || rx_ready_i)) begin
         rx_data_o  <= rx_shift;
         rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
         rx_valid_o <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_overrun_o  <= 1'b0;
         tx_underrun_o <= 1'b0;
      end else if (status_clr_i) begin
         rx_overrun_o  <= 1'b0;
         tx_underrun_o <= 1'b0;
      end else begin
         if (overrun_set)  rx_overrun_o  <= 1'b1;
         if (underrun_set) tx_underrun_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - directed bench for spi_slave_if, mode 0 and mode 3 instances
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ssel0 = 1'b1, sck0 = 1'b0, mosi0 = 1'b0, miso0;
   logic       ssel3 = 1'b1, sck3 = 1'b1, mosi3 = 1'b0, miso3;
   logic [7:0] tx_data0 = '0, tx_data3 = '0, rx_data0, rx_data3;
   logic       tx_valid0 = 1'b0, tx_valid3 = 1'b0, tx_ready0, tx_ready3;
   logic       rx_valid0, rx_valid3, rx_ready0 = 1'b0, rx_ready3 = 1'b0;
   logic       ovr0, ovr3, unr0, unr3, clr0 = 1'b0, clr3 = 1'b0, busy0, busy3;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   spi_slave_if #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
      .clk_i(clk), .reset_n_i(reset_n), .spi_ssel_i(ssel0), .spi_sck_i(sck0),
      .spi_mosi_i(mosi0), .spi_miso_o(miso0), .tx_data_i(tx_data0), .tx_valid_i(tx_valid0),
      .tx_ready_o(tx_ready0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0),
      .rx_ready_i(rx_ready0), .rx_overrun_o(ovr0), .tx_underrun_o(unr0),
      .status_clr_i(clr0), .busy_o(busy0));

   spi_slave_if #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
      .clk_i(clk), .reset_n_i(reset_n), .spi_ssel_i(ssel3), .spi_sck_i(sck3),
      .spi_mosi_i(mosi3), .spi_miso_o(miso3), .tx_data_i(tx_data3), .tx_valid_i(tx_valid3),
      .tx_ready_o(tx_ready3), .rx_data_o(rx_data3), .rx_valid_o(rx_valid3),
      .rx_ready_i(rx_ready3), .rx_overrun_o(ovr3), .tx_underrun_o(unr3),
      .status_clr_i(clr3), .busy_o(busy3));

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input bit m3, input bit mo, output bit mi);
      if (!m3) begin
         mosi0 = mo;
         wait_clks(8);
         mi = miso0;
         sck0 = 1'b1;
         wait_clks(8);
         sck0 = 1'b0;
      end else begin
         sck3 = 1'b0;
         mosi3 = mo;
         wait_clks(8);
         mi = miso3;
         sck3 = 1'b1;
         wait_clks(8);
      end
   endtask

   task automatic spi_word(input bit m3, input logic [7:0] mo, output logic [7:0] mi);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(m3, mo[i], b);
         mi[i] = b;
      end
   endtask

   task automatic tx_write(input bit m3, input logic [7:0] d);
      if (m3) begin tx_data3 = d; tx_valid3 = 1'b1; end
      else begin tx_data0 = d; tx_valid0 = 1'b1; end
      wait_clks(1);
      tx_valid0 = 1'b0;
      tx_valid3 = 1'b0;
   endtask

   task automatic rx_pop(input bit m3);
      if (m3) rx_ready3 = 1'b1; else rx_ready0 = 1'b1;
      wait_clks(1);
      rx_ready0 = 1'b0;
      rx_ready3 = 1'b0;
   endtask

   task automatic status_clear();
      clr0 = 1'b1;
      wait_clks(1);
      clr0 = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso0); end
      checks++; if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready0); end
      checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid0); end
      checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data0); end
      checks++; if ({ovr0, unr0, busy0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ovr0, unr0, busy0}); end
   endtask

   task automatic test_mode0();
      logic [7:0] mi;
      bit b;
      tx_write(1'b0, 8'hA5);
      checks++; if (tx_ready0 !== 1'b0) begin errors++; $display("FAIL m0_hold_full got %b exp 0", tx_ready0); end
      ssel0 = 1'b0;
      wait_clks(3);
      checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL m0_miso_early got %b exp 0", miso0); end
      wait_clks(1);
      checks++; if (miso0 !== 1'b1) begin errors++; $display("FAIL m0_miso_msb got %b exp 1", miso0); end
      checks++; if (tx_ready0 !== 1'b1) begin errors++; $display("FAIL m0_hold_consumed got %b exp 1", tx_ready0); end
      wait_clks(6);
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL m0_busy got %b exp 1", busy0); end
      for (int i = 7; i >= 1; i--) begin
         spi_bit(1'b0, i[2] ^ i[1] ? 1'b1 : 1'b0, b);
         mi[i] = b;
      end
      mosi0 = 1'b0;
      wait_clks(8);
      mi[0] = miso0;
      sck0 = 1'b1;
      wait_clks(3);
      checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL m0_rx_valid_early got %b exp 0", rx_valid0); end
      wait_clks(1);
      checks++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL m0_rx_valid got %b exp 1", rx_valid0); end
      wait_clks(4);
      sck0 = 1'b0;
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(8);
      checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL m0_miso_byte got %h exp a5", mi); end
      checks++; if (rx_data0 !== 8'h3C) begin errors++; $display("FAIL m0_rx_data got %h exp 3c", rx_data0); end
      checks++; if (rx_valid0 !== 1'b1) begin errors++; $display("FAIL m0_rx_held got %b exp 1", rx_valid0); end
      checks++; if ({ovr0, unr0, busy0} !== 3'b000) begin errors++; $display("FAIL m0_flags got %b exp 000", {ovr0, unr0, busy0}); end
      rx_pop(1'b0);
      checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL m0_rx_pop got %b exp 0", rx_valid0); end
   endtask

   task automatic test_mode3();
      logic [7:0] mo [3] = '{8'h01, 8'h80, 8'hFF};
      logic [7:0] exp_mi [3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0] mi [3];
      tx_write(1'b1, 8'h11);
      ssel3 = 1'b0;
      fork
         begin
            wait_clks(10);
            for (int w = 0; w < 3; w++) begin
               spi_word(1'b1, mo[w], mi[w]);
               checks++; if ({rx_valid3, rx_data3} !== {1'b1, mo[w]}) begin errors++; $display("FAIL m3_rx_word%0d got %b/%h exp 1/%h", w, rx_valid3, rx_data3, mo[w]); end
               rx_pop(1'b1);
            end
            wait_clks(8);
            ssel3 = 1'b1;
            wait_clks(8);
         end
         begin
            wait_clks(20);
            tx_write(1'b1, 8'h22);
            wait_clks(140);
            tx_write(1'b1, 8'h33);
         end
      join
      for (int w = 0; w < 3; w++) begin
         checks++; if (mi[w] !== exp_mi[w]) begin errors++; $display("FAIL m3_miso_word%0d got %h exp %h", w, mi[w], exp_mi[w]); end
      end
      checks++; if ({ovr3, unr3, rx_valid3} !== 3'b000) begin errors++; $display("FAIL m3_flags got %b exp 000", {ovr3, unr3, rx_valid3}); end
   endtask

   task automatic test_underrun();
      logic [7:0] mi1, mi2;
      tx_write(1'b0, 8'hC3);
      ssel0 = 1'b0;
      wait_clks(10);
      spi_word(1'b0, 8'h5A, mi1);
      checks++; if (unr0 !== 1'b0) begin errors++; $display("FAIL ur_between got %b exp 0", unr0); end
      rx_pop(1'b0);
      spi_word(1'b0, 8'h5B, mi2);
      checks++; if (rx_data0 !== 8'h5B) begin errors++; $display("FAIL ur_rx_word2 got %h exp 5b", rx_data0); end
      rx_pop(1'b0);
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(20);
      checks++; if (mi1 !== 8'hC3) begin errors++; $display("FAIL ur_miso_word1 got %h exp c3", mi1); end
      checks++; if (mi2 !== 8'h00) begin errors++; $display("FAIL ur_miso_word2 got %h exp 00", mi2); end
      checks++; if (unr0 !== 1'b1) begin errors++; $display("FAIL ur_sticky got %b exp 1", unr0); end
      status_clear();
      checks++; if (unr0 !== 1'b0) begin errors++; $display("FAIL ur_clear got %b exp 0", unr0); end
   endtask

   task automatic test_overrun();
      logic [7:0] mi;
`ifdef SPI_SLAVE_RX_FIFO_EN
      logic [7:0] words [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      ssel0 = 1'b0;
      wait_clks(10);
      for (int w = 0; w < 5; w++) spi_word(1'b0, words[w], mi);
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(8);
      checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ov_flag got %b exp 1", ovr0); end
      for (int w = 0; w < 4; w++) begin
         checks++; if ({rx_valid0, rx_data0} !== {1'b1, words[w]}) begin errors++; $display("FAIL ov_fifo%0d got %b/%h exp 1/%h", w, rx_valid0, rx_data0, words[w]); end
         rx_pop(1'b0);
      end
`else
      ssel0 = 1'b0;
      wait_clks(10);
      spi_word(1'b0, 8'h12, mi);
      spi_word(1'b0, 8'h34, mi);
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(8);
      checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ov_flag got %b exp 1", ovr0); end
      checks++; if ({rx_valid0, rx_data0} !== {1'b1, 8'h12}) begin errors++; $display("FAIL ov_kept got %b/%h exp 1/12", rx_valid0, rx_data0); end
      rx_pop(1'b0);
`endif
      checks++; if (rx_valid0 !== 1'b0) begin errors++; $display("FAIL ov_drained got %b exp 0", rx_valid0); end
      status_clear();
      checks++; if ({ovr0, unr0} !== 2'b00) begin errors++; $display("FAIL ov_clear got %b exp 00", {ovr0, unr0}); end
   endtask

   task automatic test_partial();
      logic [7:0] mi;
      bit b;
      ssel0 = 1'b0;
      wait_clks(10);
      for (int i = 0; i < 5; i++) spi_bit(1'b0, i[0], b);
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(10);
      checks++; if ({rx_valid0, busy0} !== 2'b00) begin errors++; $display("FAIL part_no_word got %b exp 00", {rx_valid0, busy0}); end
      ssel0 = 1'b0;
      wait_clks(10);
      spi_word(1'b0, 8'h96, mi);
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(8);
      checks++; if ({rx_valid0, rx_data0} !== {1'b1, 8'h96}) begin errors++; $display("FAIL part_next got %b/%h exp 1/96", rx_valid0, rx_data0); end
      rx_pop(1'b0);
      status_clear();
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi;
      bit b;
      tx_write(1'b0, 8'hFF);
      ssel0 = 1'b0;
      wait_clks(10);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b1, b);
      tx_write(1'b0, 8'h42);
      checks++; if ({busy0, miso0, tx_ready0} !== 3'b110) begin errors++; $display("FAIL rm_pre got %b exp 110", {busy0, miso0, tx_ready0}); end
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if ({busy0, miso0, tx_ready0, rx_valid0, ovr0, unr0} !== 6'b001000) begin errors++; $display("FAIL rm_async got %b exp 001000", {busy0, miso0, tx_ready0, rx_valid0, ovr0, unr0}); end
      checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL rm_rx_data got %h exp 00", rx_data0); end
      wait_clks(3);
      reset_n = 1'b1;
      wait_clks(20);
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rm_no_restart got %b exp 0", busy0); end
      ssel0 = 1'b1;
      wait_clks(8);
      ssel0 = 1'b0;
      wait_clks(10);
      spi_word(1'b0, 8'hE7, mi);
      wait_clks(8);
      ssel0 = 1'b1;
      wait_clks(8);
      checks++; if ({rx_valid0, rx_data0} !== {1'b1, 8'hE7}) begin errors++; $display("FAIL rm_frame got %b/%h exp 1/e7", rx_valid0, rx_data0); end
   endtask

   initial begin
      wait_clks(3);
      reset_n = 1'b1;
      wait_clks(4);
      test_reset();
      test_mode0();
      test_mode3();
      test_underrun();
      test_overrun();
      test_partial();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
